// File: rtl/decoder_onehot_seq_pkg.sv
// ---------------------------------------------------------------------------
// decoder_onehot_seq_pkg
//   Shared definitions for the registered one-hot decoder:
//     state_t     - FSM state encoding (ST_IDLE = 0, ST_SWEEP = 1)
//     clog2_min1  - ceil(log2(n)), never smaller than 1, for counter sizing
// ---------------------------------------------------------------------------
package decoder_onehot_seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Smallest width w >= 1 such that 2**w >= n.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_onehot_seq_onehot_decode.sv
// ---------------------------------------------------------------------------
// onehot_decode
//   Combinational SEL_W -> OUT_N one-hot decoder with range check.
//   Ports:
//     idx     in   SEL_W   index to decode
//     onehot  out  OUT_N   1 << idx when idx < OUT_N, otherwise all zero
//     oor     out  1       idx >= OUT_N
// ---------------------------------------------------------------------------
module onehot_decode #(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16
) (
    input  logic [SEL_W-1:0] idx,
    output logic [OUT_N-1:0] onehot,
    output logic             oor
);

    always_comb begin
        oor    = (32'(idx) >= 32'(OUT_N));
        onehot = '0;
        // Per-bit compare keeps the result zero for out-of-range indices
        // without relying on shift truncation.
        for (int i = 0; i < OUT_N; i++) begin
            onehot[i] = (32'(idx) == 32'(i));
        end
    end

endmodule

// File: rtl/decoder_onehot_seq.sv
// ---------------------------------------------------------------------------
// decoder_onehot_seq
//   Registered one-hot decoder with a valid/ready request port and a sweep
//   mode that strobes every output once, in order.
//   Ports:
//     clk          in   1       rising-edge clock
//     rst_n        in   1       asynchronous active-low reset
//     en           in   1       global enable; 0 forces f=0 and pauses sweep
//     req_valid    in   1       single-decode request
//     req_ready    out  1       combinational: IDLE & en & ~sweep_start
//     sel          in   SEL_W   select, sampled on accept
//     sweep_start  in   1       start a sweep (sampled in IDLE only)
//     f            out  OUT_N   registered one-hot (or zero) strobe
//     f_valid      out  1       f holds a live strobe
//     sel_err      out  1       one-cycle pulse: accepted sel >= OUT_N
//     busy         out  1       sweep in progress (also exposes FSM state)
//     done         out  1       one-cycle pulse alongside the last strobe
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1; sel is sampled on that edge and the strobe (or
//   sel_err) is visible for exactly the following cycle. req_valid may stay
//   high across edges, giving one strobe per cycle.
// ---------------------------------------------------------------------------
module decoder_onehot_seq
    import decoder_onehot_seq_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             sweep_start,
    output logic [OUT_N-1:0] f,
    output logic             f_valid,
    output logic             sel_err,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = clog2_min1(OUT_N);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [OUT_N-1:0] f_d;
    logic             f_valid_d, sel_err_d, done_d;

    logic             accept, start, last;
    logic [SEL_W-1:0] idx;
    logic [OUT_N-1:0] dec;
    logic             dec_oor;

    assign req_ready = (state == ST_IDLE) & en & ~sweep_start;
    assign accept    = req_ready & req_valid;
    assign start     = (state == ST_IDLE) & en & sweep_start;
    assign last      = (32'(cnt) == 32'(OUT_N - 1));
    assign busy      = (state == ST_SWEEP);

    // cnt is the index of the next sweep strobe. It is 0 in IDLE, so the
    // start edge itself issues strobe 0 and the sweep occupies exactly
    // OUT_N strobe cycles followed by the done-cycle exit.
    assign idx = (state == ST_IDLE && !start) ? sel : SEL_W'(cnt);

    onehot_decode #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_decode (
        .idx    (idx),
        .onehot (dec),
        .oor    (dec_oor)
    );

    // State register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            f       <= '0;
            f_valid <= 1'b0;
            sel_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            f       <= f_d;
            f_valid <= f_valid_d;
            sel_err <= sel_err_d;
            done    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SWEEP: begin
                // done high means the last strobe is already on f.
                if (done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (en && !last) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        f_d       = '0;
        f_valid_d = 1'b0;
        sel_err_d = 1'b0;
        done_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    f_d       = dec;
                    f_valid_d = 1'b1;
                end else if (accept) begin
                    f_d       = dec;
                    f_valid_d = ~dec_oor;
                    sel_err_d = dec_oor;
                end
            end
            ST_SWEEP: begin
                if (!done && en) begin
                    f_d       = dec;
                    f_valid_d = 1'b1;
                    done_d    = last;
                end
            end
            default: begin
                f_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
module tb_decoder_onehot_seq;

    logic        clk;
    logic        rst_n;

    logic        en, req_valid, sweep_start;
    logic [3:0]  sel;
    logic        req_ready;
    logic [15:0] f;
    logic        f_valid, sel_err, busy, done;

    logic        en10, req_valid10, sweep_start10;
    logic [3:0]  sel10;
    logic        req_ready10;
    logic [9:0]  f10;
    logic        f_valid10, sel_err10, busy10, done10;

    int n_cmp;
    int n_bad;

    decoder_onehot_seq #(.SEL_W(4), .OUT_N(16)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .sel         (sel),
        .sweep_start (sweep_start),
        .f           (f),
        .f_valid     (f_valid),
        .sel_err     (sel_err),
        .busy        (busy),
        .done        (done)
    );

    decoder_onehot_seq #(.SEL_W(4), .OUT_N(10)) dut10 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en10),
        .req_valid   (req_valid10),
        .req_ready   (req_ready10),
        .sel         (sel10),
        .sweep_start (sweep_start10),
        .f           (f10),
        .f_valid     (f_valid10),
        .sel_err     (sel_err10),
        .busy        (busy10),
        .done        (done10)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample and drive 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1; req_valid = 1'b0; sweep_start = 1'b0; sel = '0;
        en10 = 1'b1; req_valid10 = 1'b0; sweep_start10 = 1'b0; sel10 = '0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if ({f, f_valid, sel_err, busy, done} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset16 f=%h fv=%b err=%b busy=%b done=%b req=0", f, f_valid, sel_err, busy, done);
        end
        n_cmp++;
        if ({f10, f_valid10, sel_err10, busy10, done10} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset10 f=%h fv=%b err=%b busy=%b done=%b req=0", f10, f_valid10, sel_err10, busy10, done10);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got=%b req=1", req_ready);
        end
    endtask

    task automatic test_single();
        req_valid = 1'b1; sel = 4'd5;
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (f !== 16'h0020 || f_valid !== 1'b1 || sel_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_strobe f=%h fv=%b err=%b req f=0020 fv=1 err=0", f, f_valid, sel_err);
        end
        tick();
        n_cmp++;
        if (f !== 16'h0000 || f_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_clear f=%h fv=%b req f=0000 fv=0", f, f_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sv [3];
        logic [15:0] ev [3];
        sv[0] = 4'd3;  ev[0] = 16'h0008;
        sv[1] = 4'd15; ev[1] = 16'h8000;
        sv[2] = 4'd0;  ev[2] = 16'h0001;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = sv[i];
            tick();
            n_cmp++;
            if (f !== ev[i] || f_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b[%0d] f=%h fv=%b req f=%h fv=1", i, f, f_valid, ev[i]);
            end
        end
        req_valid = 1'b0;
        tick();
        n_cmp++;
        if (f !== 16'h0000) begin
            n_bad++;
            $display("FAIL b2b_clear f=%h req=0000", f);
        end
    endtask

    task automatic test_enable_idle();
        req_valid = 1'b1; sel = 4'd7;
        tick();
        en = 1'b0; sel = 4'd2;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL en0_ready got=%b req=0", req_ready);
        end
        n_cmp++;
        if (f !== 16'h0080) begin
            n_bad++;
            $display("FAIL en0_prev f=%h req=0080", f);
        end
        tick();
        n_cmp++;
        if (f !== 16'h0000 || f_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL en0_clear f=%h fv=%b req f=0000 fv=0", f, f_valid);
        end
        req_valid = 1'b0; en = 1'b1;
        tick();
    endtask

    task automatic test_out_of_range();
        req_valid10 = 1'b1; sel10 = 4'd12;
        tick();
        req_valid10 = 1'b0;
        n_cmp++;
        if (f10 !== 10'h000 || f_valid10 !== 1'b0 || sel_err10 !== 1'b1) begin
            n_bad++;
            $display("FAIL oor12 f=%h fv=%b err=%b req f=000 fv=0 err=1", f10, f_valid10, sel_err10);
        end
        tick();
        n_cmp++;
        if (sel_err10 !== 1'b0) begin
            n_bad++;
            $display("FAIL oor12_pulse err=%b req=0", sel_err10);
        end
        req_valid10 = 1'b1; sel10 = 4'd9;
        tick();
        sel10 = 4'd10;
        n_cmp++;
        if (f10 !== 10'h200 || f_valid10 !== 1'b1 || sel_err10 !== 1'b0) begin
            n_bad++;
            $display("FAIL edge9 f=%h fv=%b err=%b req f=200 fv=1 err=0", f10, f_valid10, sel_err10);
        end
        tick();
        req_valid10 = 1'b0;
        n_cmp++;
        if (f10 !== 10'h000 || f_valid10 !== 1'b0 || sel_err10 !== 1'b1) begin
            n_bad++;
            $display("FAIL oor10 f=%h fv=%b err=%b req f=000 fv=0 err=1", f10, f_valid10, sel_err10);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] exp_f;
        sweep_start = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL sweep_ready got=%b req=0", req_ready);
        end
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_f = 16'h0001 << k;
            n_cmp++;
            if (f !== exp_f || f_valid !== 1'b1 || busy !== 1'b1 || done !== (k == 15)) begin
                n_bad++;
                $display("FAIL sweep[%0d] f=%h fv=%b busy=%b done=%b req f=%h fv=1 busy=1 done=%b",
                         k, f, f_valid, busy, done, exp_f, (k == 15));
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || f !== 16'h0000 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_end busy=%b done=%b f=%h rdy=%b req busy=0 done=0 f=0000 rdy=1",
                     busy, done, f, req_ready);
        end
    endtask

    task automatic test_sweep_pause();
        logic [15:0] exp_f;
        int strobes;
        strobes = 0;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_f = 16'h0001 << k;
            if (f_valid === 1'b1) strobes++;
            n_cmp++;
            if (f !== exp_f || f_valid !== 1'b1 || done !== (k == 15)) begin
                n_bad++;
                $display("FAIL pause_sweep[%0d] f=%h fv=%b done=%b req f=%h fv=1 done=%b",
                         k, f, f_valid, done, exp_f, (k == 15));
            end
            if (k == 5) begin
                en = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    tick();
                    n_cmp++;
                    if (f !== 16'h0000 || f_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                        n_bad++;
                        $display("FAIL pause[%0d] f=%h fv=%b busy=%b done=%b req f=0000 fv=0 busy=1 done=0",
                                 p, f, f_valid, busy, done);
                    end
                end
                en = 1'b1;
            end
            tick();
        end
        n_cmp++;
        if (strobes !== 16 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_total strobes=%0d busy=%b req strobes=16 busy=0", strobes, busy);
        end
    endtask

    task automatic test_sweep_vs_request();
        logic [15:0] exp_f;
        sweep_start = 1'b1; req_valid = 1'b1; sel = 4'd3;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_ready got=%b req=0", req_ready);
        end
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_f = 16'h0001 << k;
            n_cmp++;
            if (f !== exp_f || req_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL prio_sweep[%0d] f=%h rdy=%b busy=%b req f=%h rdy=0 busy=1",
                         k, f, req_ready, busy, exp_f);
            end
            tick();
        end
        n_cmp++;
        if (f !== 16'h0000 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_idle f=%h busy=%b rdy=%b req f=0000 busy=0 rdy=1", f, busy, req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (f !== 16'h0008 || f_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_held f=%h fv=%b req f=0008 fv=1", f, f_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (f !== 16'h0100 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre f=%h busy=%b req f=0100 busy=1", f, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (f !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || f_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset f=%h busy=%b done=%b fv=%b req all 0", f, busy, done, f_valid);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || f !== 16'h0000 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset[%0d] done=%b f=%h busy=%b req 0 0000 0", i, done, f, busy);
            end
        end
        req_valid = 1'b1; sel = 4'd9;
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (f !== 16'h0200 || f_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_req f=%h fv=%b req f=0200 fv=1", f, f_valid);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_idle();
        test_out_of_range();
        test_sweep();
        test_sweep_pause();
        test_sweep_vs_request();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
